// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: runs one data-memory transaction per load/store,
// holds the pipeline until it completes, and formats load data for MEM/WB.
module mem_lsu #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_MemRead,
    input  logic              MEM_MemWrite,
    input  logic [2:0]        MEM_funct3,
    input  logic [ADDR_W-1:0] MEM_alu_out,
    input  logic [DATA_W-1:0] MEM_rs2_data,
    input  logic              pipe_adv,
    output logic              dm_req,
    output logic              dm_we,
    output logic [3:0]        dm_be,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ready,
    input  logic              dm_rvalid,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic [DATA_W-1:0] MEM_mem_data,
    output logic              lsu_stall,
    output logic              misalign,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RDATA,
        S_DONE
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_dm_req;
    logic              r_dm_we;
    logic [3:0]        r_dm_be;
    logic [ADDR_W-1:0] r_dm_addr;
    logic [DATA_W-1:0] r_dm_wdata;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_misalign;
    logic              r_bus_err;
    logic [1:0]        r_lo;
    logic [2:0]        r_f3;

    logic              w_op;
    logic              w_misalign;
    logic              w_cnt_last;
    logic [1:0]        w_lo;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load_data;

    assign w_op       = MEM_MemRead | MEM_MemWrite;
    assign w_lo       = MEM_alu_out[1:0];
    assign w_cnt_last = (r_cnt == CNT_LAST);
    // funct3[1:0]: 00 byte, 01 half, 1x word
    assign w_misalign = ((MEM_funct3[1:0] == 2'b01) && w_lo[0]) ||
                        (MEM_funct3[1] && (w_lo != 2'b00));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = MEM_rs2_data;
        if (!MEM_MemRead) begin
            case (MEM_funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << w_lo;
                    w_wdata = {4{MEM_rs2_data[7:0]}};
                end
                2'b01: begin
                    w_be    = MEM_alu_out[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{MEM_rs2_data[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = MEM_rs2_data;
                end
            endcase
        end
    end

    always_comb begin
        case (r_lo)
            2'd0:    w_byte = dm_rdata[7:0];
            2'd1:    w_byte = dm_rdata[15:8];
            2'd2:    w_byte = dm_rdata[23:16];
            default: w_byte = dm_rdata[31:24];
        endcase
        w_half = r_lo[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (r_f3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'b0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'b0, w_half};
            default: w_load_data = dm_rdata;
        endcase
    end

    // A read's ready is not completion, so the timeout still wins on the last count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_be    <= '0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
            r_mem_data <= '0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            r_lo       <= '0;
            r_f3       <= '0;
        end else begin
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_op) begin
                        if (w_misalign) begin
                            r_state    <= S_DONE;
                            r_misalign <= 1'b1;
                            r_mem_data <= '0;
                        end else begin
                            r_state    <= S_REQ;
                            r_cnt      <= '0;
                            r_dm_req   <= 1'b1;
                            r_dm_we    <= !MEM_MemRead;
                            r_dm_be    <= w_be;
                            r_dm_addr  <= {MEM_alu_out[ADDR_W-1:2], 2'b00};
                            r_dm_wdata <= w_wdata;
                            r_lo       <= w_lo;
                            r_f3       <= MEM_funct3;
                        end
                    end
                end
                S_REQ: begin
                    if (dm_ready && r_dm_we) begin
                        r_dm_req <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (w_cnt_last) begin
                        r_dm_req   <= 1'b0;
                        r_state    <= S_DONE;
                        r_bus_err  <= 1'b1;
                        r_mem_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (dm_ready) begin
                            r_dm_req <= 1'b0;
                            r_state  <= S_RDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (dm_rvalid) begin
                        r_mem_data <= w_load_data;
                        r_state    <= S_DONE;
                    end else if (w_cnt_last) begin
                        r_state    <= S_DONE;
                        r_bus_err  <= 1'b1;
                        r_mem_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (pipe_adv) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dm_req       = r_dm_req;
    assign dm_we        = r_dm_we;
    assign dm_be        = r_dm_be;
    assign dm_addr      = r_dm_addr;
    assign dm_wdata     = r_dm_wdata;
    assign MEM_mem_data = r_mem_data;
    assign misalign     = r_misalign;
    assign bus_err      = r_bus_err;
    assign lsu_stall    = w_op && (r_state != S_DONE);

endmodule
